// File: rtl/image_receiver.sv
// image_receiver
//   Downstream end of an image pipe. Requests one frame, accepts pixels under
//   Ready/Valid flow control, checks Start/Stop framing against the expected
//   geometry, keeps a running data checksum and captures one probe pixel.
//
//   Parameters
//     Width, Height  frame geometry in pixels
//     DataWidth      width of the pixel Data word
//     Timeout        cycles without an accepted pixel before aborting (0 = never)
//     ChecksumWidth  width of the running data sum
//
//   Ports
//     clock, reset        system clock, synchronous active-high reset
//     go                  start a frame capture (only honoured when idle or done)
//     abort               cancel the frame in progress
//     ready_enable        gates Ready (backpressure)
//     probe_x, probe_y    position of the pixel whose Data is captured
//     request, cancel,
//     ready               sink-driven pipe signals
//     start, stop, valid,
//     error, data         source-driven pipe signals
//     busy                frame in progress
//     done                one-cycle pulse at frame end (normal or error)
//     pixel_count         pixels accepted this frame
//     checksum            sum of accepted Data, modulo 2^ChecksumWidth
//     probe_data          Data of the pixel at (probe_x, probe_y)
//     status              sticky flags: [0] start [1] stop [2] short
//                         [3] upstream [4] timeout
module image_receiver #(
  parameter int Width         = 4,
  parameter int Height        = 3,
  parameter int DataWidth     = 24,
  parameter int Timeout       = 1024,
  parameter int ChecksumWidth = 32,
  localparam int XW = (Width > 1) ? $clog2(Width) : 1,
  localparam int YW = (Height > 1) ? $clog2(Height) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     go,
  input  logic                     abort,
  input  logic                     ready_enable,
  input  logic [XW-1:0]            probe_x,
  input  logic [YW-1:0]            probe_y,
  output logic                     request,
  output logic                     cancel,
  output logic                     ready,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     valid,
  input  logic                     error,
  input  logic [DataWidth-1:0]     data,
  output logic                     busy,
  output logic                     done,
  output logic [31:0]              pixel_count,
  output logic [ChecksumWidth-1:0] checksum,
  output logic [DataWidth-1:0]     probe_data,
  output logic [4:0]               status
);

  typedef enum logic [2:0] {
    IDLE,
    REQUEST,
    RECEIVE,
    CANCEL,
    DONE
  } state_t;

  state_t                   state_reg, state_next;
  logic [XW-1:0]            x_reg;
  logic [YW-1:0]            y_reg;
  logic [31:0]              idle_cycles_reg;
  logic                     done_reg;
  logic [31:0]              count_reg;
  logic [ChecksumWidth-1:0] checksum_reg;
  logic [DataWidth-1:0]     probe_reg;
  logic [4:0]               status_reg;

  logic accept;
  logic at_origin;
  logic at_last;
  logic at_row_end;
  logic timeout_hit;
  logic start_frame;

  // Pipe control is decoded directly from the state register, so it is glitch
  // free; ready_enable only masks Ready for backpressure.
  assign request = (state_reg == REQUEST);
  assign cancel  = (state_reg == CANCEL);
  assign ready   = (state_reg == RECEIVE) && ready_enable;
  assign busy    = (state_reg == REQUEST) || (state_reg == RECEIVE) || (state_reg == CANCEL);
  assign done    = done_reg;

  assign accept      = valid && ready;
  assign at_origin   = (x_reg == '0) && (y_reg == '0);
  assign at_row_end  = (x_reg == XW'(Width - 1));
  assign at_last     = at_row_end && (y_reg == YW'(Height - 1));
  // The counter holds the number of idle RECEIVE cycles already elapsed, so the
  // current idle cycle is the Timeout-th one when it equals Timeout-1.
  assign timeout_hit = (Timeout != 0) && (idle_cycles_reg == 32'(Timeout - 1));
  assign start_frame = go && ((state_reg == IDLE) || (state_reg == DONE));

  assign pixel_count = count_reg;
  assign checksum    = checksum_reg;
  assign probe_data  = probe_reg;
  assign status      = status_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // abort outranks frame end and timeout; an accept in the same cycle is still
  // counted by the datapath below.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (go) state_next = REQUEST;
      REQUEST: state_next = abort ? CANCEL : RECEIVE;
      RECEIVE: begin
        if (abort) begin
          state_next = CANCEL;
        end else if (accept && (at_last || stop)) begin
          state_next = DONE;
        end else if (!accept && timeout_hit) begin
          state_next = CANCEL;
        end
      end
      // The timeout flag was set on the edge that entered CANCEL, so it tells
      // a timed-out frame (which reports done) from a user abort (which does not).
      CANCEL:  state_next = status_reg[4] ? DONE : IDLE;
      DONE:    if (go) state_next = REQUEST;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x_reg           <= '0;
      y_reg           <= '0;
      idle_cycles_reg <= '0;
      done_reg        <= 1'b0;
      count_reg       <= '0;
      checksum_reg    <= '0;
      probe_reg       <= '0;
      status_reg      <= '0;
    end else begin
      done_reg <= (state_next == DONE) && (state_reg != DONE);
      if (start_frame) begin
        x_reg           <= '0;
        y_reg           <= '0;
        idle_cycles_reg <= '0;
        count_reg       <= '0;
        checksum_reg    <= '0;
        probe_reg       <= '0;
        status_reg      <= '0;
      end else if (state_reg == RECEIVE) begin
        if (accept) begin
          idle_cycles_reg <= '0;
          count_reg       <= count_reg + 32'd1;
          checksum_reg    <= checksum_reg + ChecksumWidth'(data);
          if ((x_reg == probe_x) && (y_reg == probe_y)) begin
            probe_reg <= data;
          end
          if (at_row_end) begin
            x_reg <= '0;
            y_reg <= y_reg + YW'(1);
          end else begin
            x_reg <= x_reg + XW'(1);
          end
          if (start != at_origin) status_reg[0] <= 1'b1;
          if (at_last && !stop)   status_reg[1] <= 1'b1;
          if (stop && !at_last)   status_reg[2] <= 1'b1;
          if (error)              status_reg[3] <= 1'b1;
        end else begin
          idle_cycles_reg <= idle_cycles_reg + 32'd1;
          if (timeout_hit && !abort) status_reg[4] <= 1'b1;
        end
      end
    end
  end

endmodule
